// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode encodings: opcodes, control-field codes, immediate types and bundle structs.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSR_NONE = 3'b100;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_COPY1 = 5'd10;
  localparam logic [4:0] ALU_COPY2 = 5'd11;
  localparam logic [4:0] ALU_JALR  = 5'd12;
  localparam logic [4:0] ALU_MUL   = 5'd16;  // MUL..REMU = ALU_MUL + funct3
  localparam logic [4:0] ALU_REMU  = 5'd23;
  localparam logic [4:0] ALU_X     = 5'd31;

  localparam logic [1:0] RS1_RS1 = 2'd0;
  localparam logic [1:0] RS1_PC  = 2'd1;
  localparam logic [1:0] RS1_X   = 2'd2;
  localparam logic [1:0] RS2_RS2 = 2'd0;
  localparam logic [1:0] RS2_IMI = 2'd1;
  localparam logic [1:0] RS2_X   = 2'd2;

  // Load codes equal funct3; stores occupy the unused slots.
  localparam logic [2:0] MEM_LB  = 3'd0;
  localparam logic [2:0] MEM_LH  = 3'd1;
  localparam logic [2:0] MEM_LW  = 3'd2;
  localparam logic [2:0] MEM_SB  = 3'd3;
  localparam logic [2:0] MEM_LBU = 3'd4;
  localparam logic [2:0] MEM_LHU = 3'd5;
  localparam logic [2:0] MEM_SH  = 3'd6;
  localparam logic [2:0] MEM_SW  = 3'd7;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_X   = 2'd3;

  localparam logic [2:0] BR_X    = 3'd0;
  localparam logic [2:0] BR_J    = 3'd1;
  localparam logic [2:0] BR_BEQ  = 3'd2;
  localparam logic [2:0] BR_BNE  = 3'd3;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;

  typedef enum logic [2:0] {IMM_Z, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  alu_fn;
    logic [1:0]  rs1_sel;
    logic [1:0]  rs2_sel;
    logic [2:0]  mem_fn;
    logic [1:0]  wb_sel;
    logic [2:0]  br;
    logic [2:0]  csr_fn;
    logic        ecall;
    logic        illegal;
  } id_meta_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_type_e t);
    logic [31:0] r;
    r = '0;
    case (t)
      IMM_I:   r = {{20{i[31]}}, i[31:20]};
      IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   r = {i[31:12], 12'b0};
      IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] alu_base(input logic [2:0] f3);
    logic [4:0] r;
    r = ALU_X;
    case (f3)
      3'b000: r = ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: r = ALU_SRL;
      3'b110: r = ALU_OR;
      3'b111: r = ALU_AND;
      default: r = ALU_X;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV32I(+M, +Zicsr) instruction word -> control bundle.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a; the caller registers the result.
module rv_decode_comb
  import decode_stage_pkg::*;
#(
  parameter bit EN_M   = 1'b0,
  parameter bit EN_CSR = 1'b1
) (
  input  logic [31:0] inst,
  output logic [31:0] imm,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [4:0]  alu_fn,
  output logic [1:0]  rs1_sel,
  output logic [1:0]  rs2_sel,
  output logic [2:0]  mem_fn,
  output logic [1:0]  wb_sel,
  output logic [2:0]  br,
  output logic [2:0]  csr_fn,
  output logic        ecall,
  output logic        illegal
);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       legal;
  imm_type_e  imm_t;

  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign f7       = inst[31:25];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];
  assign rd_addr  = inst[11:7];

  always_comb begin
    imm_t   = IMM_Z;
    alu_fn  = ALU_X;
    rs1_sel = RS1_X;
    rs2_sel = RS2_X;
    mem_fn  = MEM_LB;
    wb_sel  = WB_X;
    br      = BR_X;
    csr_fn  = 3'b000;
    ecall   = 1'b0;
    legal   = 1'b0;
    case (opc)
      OPC_LUI: begin
        legal = 1'b1; imm_t = IMM_U; rs2_sel = RS2_IMI; alu_fn = ALU_COPY2; wb_sel = WB_ALU;
      end
      OPC_AUIPC: begin
        legal = 1'b1; imm_t = IMM_U; rs1_sel = RS1_PC; rs2_sel = RS2_IMI; alu_fn = ALU_ADD; wb_sel = WB_ALU;
      end
      OPC_JAL: begin
        legal = 1'b1; imm_t = IMM_J; rs1_sel = RS1_PC; rs2_sel = RS2_IMI; alu_fn = ALU_ADD;
        wb_sel = WB_PC; br = BR_J;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); imm_t = IMM_I; rs1_sel = RS1_RS1; rs2_sel = RS2_IMI;
        alu_fn = ALU_JALR; wb_sel = WB_PC; br = BR_J;
      end
      OPC_BRANCH: begin
        legal = (f3[2:1] != 2'b01); imm_t = IMM_B; rs1_sel = RS1_PC; rs2_sel = RS2_IMI; alu_fn = ALU_ADD;
        br = f3[2] ? {1'b1, f3[1:0]} : (f3[0] ? BR_BNE : BR_BEQ);
      end
      OPC_LOAD: begin
        legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
        imm_t = IMM_I; rs1_sel = RS1_RS1; rs2_sel = RS2_IMI; alu_fn = ALU_ADD; mem_fn = f3; wb_sel = WB_MEM;
      end
      OPC_STORE: begin
        legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
        imm_t = IMM_S; rs1_sel = RS1_RS1; rs2_sel = RS2_IMI; alu_fn = ALU_ADD;
        mem_fn = (f3[1:0] == 2'b00) ? MEM_SB : ((f3[1:0] == 2'b01) ? MEM_SH : MEM_SW);
      end
      OPC_OP_IMM: begin
        imm_t = IMM_I; rs1_sel = RS1_RS1; rs2_sel = RS2_IMI; wb_sel = WB_ALU; alu_fn = alu_base(f3);
        legal = 1'b1;
        // Shift-immediates reuse the top of the I immediate as funct7; only SRAI may set bit 30.
        if (f3 == 3'b001) legal = (f7 == F7_BASE);
        if (f3 == 3'b101) begin
          legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
          alu_fn = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
        end
      end
      OPC_OP: begin
        rs1_sel = RS1_RS1; rs2_sel = RS2_RS2; wb_sel = WB_ALU;
        if (f7 == F7_BASE) begin
          legal = 1'b1; alu_fn = alu_base(f3);
        end else if (f7 == F7_ALT) begin
          legal  = (f3 == 3'b000) || (f3 == 3'b101);
          alu_fn = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end else if (f7 == F7_MULDIV && EN_M) begin
          legal = 1'b1; alu_fn = {2'b10, f3};
        end
      end
      OPC_FENCE: legal = (f3[2:1] == 2'b00);
      OPC_SYSTEM: begin
        if (f3 == F3_PRIV) begin
          legal = (inst[31:7] == 25'd0);
          ecall = legal;
        end else if (EN_CSR && f3 != F3_CSR_NONE) begin
          legal = 1'b1; imm_t = IMM_I; csr_fn = f3; wb_sel = WB_ALU; alu_fn = ALU_COPY1;
          rs1_sel = f3[2] ? RS1_X : RS1_RS1; rs2_sel = RS2_IMI;
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      imm_t   = IMM_Z;
      alu_fn  = ALU_X;
      rs1_sel = RS1_X;
      rs2_sel = RS2_X;
      mem_fn  = MEM_LB;
      wb_sel  = WB_X;
      br      = BR_X;
      csr_fn  = 3'b000;
      ecall   = 1'b0;
    end
    illegal = !legal;
    imm     = gen_imm(inst, imm_t);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: circular instruction queue feeding a registered decoded bundle to execute.
// Latency: 1 cycle accept->id_valid when the queue is empty (bypass), otherwise queue order.
// Backpressure: if_ready drops when the queue is full; id_* hold while id_valid && !id_ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2,
  parameter bit EN_M        = 1'b0,
  parameter bit EN_CSR      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_imm,
  output logic [4:0]  id_rs1_addr,
  output logic [4:0]  id_rs2_addr,
  output logic [4:0]  id_rd_addr,
  output logic [4:0]  id_alu_fn,
  output logic [1:0]  id_rs1_sel,
  output logic [1:0]  id_rs2_sel,
  output logic [2:0]  id_mem_fn,
  output logic [1:0]  id_wb_sel,
  output logic [2:0]  id_br,
  output logic [2:0]  id_csr_fn,
  output logic        id_ecall,
  output logic        id_illegal
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(QUEUE_DEPTH - 1);

  fetch_t             q_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               q_full, q_empty, push, load, pop, bypass, q_wr;
  fetch_t             in_dat, src_dat;
  id_meta_t           dec_dat, out_q;
  logic               out_vld;

  logic [31:0] d_imm;
  logic [4:0]  d_rs1, d_rs2, d_rd, d_alu;
  logic [1:0]  d_s1, d_s2, d_wb;
  logic [2:0]  d_mem, d_br, d_csr;
  logic        d_ecall, d_ill;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign q_full   = (count == DEPTH_C);
  assign q_empty  = (count == '0);
  assign if_ready = rst_n && !flush && !q_full;
  assign push     = if_valid && if_ready;
  assign load     = !out_vld || id_ready;
  assign pop      = load && !q_empty;
  // Bypass only when nothing older is queued, which keeps FIFO order.
  assign bypass   = load && q_empty && push;
  assign q_wr     = push && !bypass;
  assign in_dat   = '{pc: if_pc, inst: if_inst};
  assign src_dat  = q_empty ? in_dat : q_mem[rd_ptr];

  rv_decode_comb #(.EN_M(EN_M), .EN_CSR(EN_CSR)) u_dec (
    .inst     (src_dat.inst),
    .imm      (d_imm),
    .rs1_addr (d_rs1),
    .rs2_addr (d_rs2),
    .rd_addr  (d_rd),
    .alu_fn   (d_alu),
    .rs1_sel  (d_s1),
    .rs2_sel  (d_s2),
    .mem_fn   (d_mem),
    .wb_sel   (d_wb),
    .br       (d_br),
    .csr_fn   (d_csr),
    .ecall    (d_ecall),
    .illegal  (d_ill)
  );

  assign dec_dat = '{pc: src_dat.pc, imm: d_imm, rs1_addr: d_rs1, rs2_addr: d_rs2, rd_addr: d_rd,
                     alu_fn: d_alu, rs1_sel: d_s1, rs2_sel: d_s2, mem_fn: d_mem, wb_sel: d_wb,
                     br: d_br, csr_fn: d_csr, ecall: d_ecall, illegal: d_ill};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (q_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(q_wr) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (q_wr) q_mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_q   <= '0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (load) begin
      out_vld <= pop || bypass;
      if (pop || bypass) out_q <= dec_dat;
    end
  end

  assign id_valid    = out_vld;
  assign id_pc       = out_q.pc;
  assign id_imm      = out_q.imm;
  assign id_rs1_addr = out_q.rs1_addr;
  assign id_rs2_addr = out_q.rs2_addr;
  assign id_rd_addr  = out_q.rd_addr;
  assign id_alu_fn   = out_q.alu_fn;
  assign id_rs1_sel  = out_q.rs1_sel;
  assign id_rs2_sel  = out_q.rs2_sel;
  assign id_mem_fn   = out_q.mem_fn;
  assign id_wb_sel   = out_q.wb_sel;
  assign id_br       = out_q.br;
  assign id_csr_fn   = out_q.csr_fn;
  assign id_ecall    = out_q.ecall;
  assign id_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: scoreboard of expected bundles, immediate-assertion checks.
// A second instance with EN_M=1 shares the stimulus for the M-extension decode.
module tb_decode_stage;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic        id_ready = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;

  logic        if_ready, id_valid, id_ecall, id_illegal;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_fn;
  logic [1:0]  id_rs1_sel, id_rs2_sel, id_wb_sel;
  logic [2:0]  id_mem_fn, id_br, id_csr_fn;

  logic        m_if_ready, m_id_valid, m_ecall, m_illegal;
  logic [31:0] m_pc, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd, m_alu_fn;
  logic [1:0]  m_s1, m_s2, m_wb;
  logic [2:0]  m_mem, m_br, m_csr;

  always #5 clk = ~clk;

  decode_stage #(.QUEUE_DEPTH(QD), .EN_M(1'b0), .EN_CSR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_alu_fn(id_alu_fn), .id_rs1_sel(id_rs1_sel),
    .id_rs2_sel(id_rs2_sel), .id_mem_fn(id_mem_fn), .id_wb_sel(id_wb_sel), .id_br(id_br),
    .id_csr_fn(id_csr_fn), .id_ecall(id_ecall), .id_illegal(id_illegal)
  );

  decode_stage #(.QUEUE_DEPTH(QD), .EN_M(1'b1), .EN_CSR(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .flush(flush), .if_valid(if_valid), .if_ready(m_if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .id_valid(m_id_valid), .id_ready(id_ready),
    .id_pc(m_pc), .id_imm(m_imm), .id_rs1_addr(m_rs1), .id_rs2_addr(m_rs2),
    .id_rd_addr(m_rd), .id_alu_fn(m_alu_fn), .id_rs1_sel(m_s1),
    .id_rs2_sel(m_s2), .id_mem_fn(m_mem), .id_wb_sel(m_wb), .id_br(m_br),
    .id_csr_fn(m_csr), .id_ecall(m_ecall), .id_illegal(m_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic [2:0]  br;
    logic [2:0]  csr;
    logic        ec;
    logic        ill;
  } exp_t;

  exp_t tbl [12];
  exp_t drv;
  exp_t sb [$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   acc;
  int   k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int idx, input logic [31:0] pc);
    drv      = tbl[idx];
    drv.pc   = pc;
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = tbl[idx].inst;
  endtask

  // Samples on the falling edge: records accepted inputs, checks delivered bundles.
  task automatic cycle();
    exp_t e;
    acc = 1'b0;
    @(negedge clk);
    if (if_valid && if_ready) begin
      sb.push_back(drv);
      acc = 1'b1;
    end
    if (id_valid && id_ready) begin
      n_chk++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL sb_underflow: observed=output pc 0x%08h expected=no output", id_pc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", id_pc, e.pc);
        chk("imm", id_imm, e.imm);
        chk("rs1_addr", {27'd0, id_rs1_addr}, {27'd0, e.inst[19:15]});
        chk("rs2_addr", {27'd0, id_rs2_addr}, {27'd0, e.inst[24:20]});
        chk("rd_addr", {27'd0, id_rd_addr}, {27'd0, e.inst[11:7]});
        chk("alu_fn", {27'd0, id_alu_fn}, {27'd0, e.alu});
        chk("rs1_sel", {30'd0, id_rs1_sel}, {30'd0, e.s1});
        chk("rs2_sel", {30'd0, id_rs2_sel}, {30'd0, e.s2});
        chk("mem_fn", {29'd0, id_mem_fn}, {29'd0, e.mem});
        chk("wb_sel", {30'd0, id_wb_sel}, {30'd0, e.wb});
        chk("br", {29'd0, id_br}, {29'd0, e.br});
        chk("csr_fn", {29'd0, id_csr_fn}, {29'd0, e.csr});
        chk("ecall", {31'd0, id_ecall}, {31'd0, e.ec});
        chk("illegal", {31'd0, id_illegal}, {31'd0, e.ill});
        if (e.inst == 32'h02208033) begin
          chk("m_alu_fn", {27'd0, m_alu_fn}, 32'd16);
          chk("m_illegal", {31'd0, m_illegal}, 32'd0);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            pc      inst          imm           alu  s1  s2  mem wb  br  csr ec ill
    tbl[0]  = '{32'h0, 32'h00500093, 32'h00000005, 5'd0, 2'd0, 2'd1, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0}; // addi x1,x0,5
    tbl[1]  = '{32'h0, 32'h02208033, 32'h00000000, 5'd31, 2'd2, 2'd2, 3'd0, 2'd3, 3'd0, 3'd0, 1'b0, 1'b1}; // mul, M off
    tbl[2]  = '{32'h0, 32'h30002573, 32'h00000300, 5'd10, 2'd0, 2'd1, 3'd0, 2'd0, 3'd0, 3'd2, 1'b0, 1'b0}; // csrrs
    tbl[3]  = '{32'h0, 32'hFE000EE3, 32'hFFFFFFFC, 5'd0, 2'd1, 2'd1, 3'd0, 2'd3, 3'd2, 3'd0, 1'b0, 1'b0}; // beq -4
    tbl[4]  = '{32'h0, 32'h004002B3, 32'h00000000, 5'd0, 2'd0, 2'd0, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0}; // add x5,x0,x4
    tbl[5]  = '{32'h0, 32'h0000006F, 32'h00000000, 5'd0, 2'd1, 2'd1, 3'd0, 2'd2, 3'd1, 3'd0, 1'b0, 1'b0}; // jal x0,0
    tbl[6]  = '{32'h0, 32'h123451B7, 32'h12345000, 5'd11, 2'd2, 2'd1, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0}; // lui
    tbl[7]  = '{32'h0, 32'h4030D093, 32'h00000403, 5'd7, 2'd0, 2'd1, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0}; // srai x1,x1,3
    tbl[8]  = '{32'h0, 32'h40309093, 32'h00000000, 5'd31, 2'd2, 2'd2, 3'd0, 2'd3, 3'd0, 3'd0, 1'b0, 1'b1}; // slli, bad funct7
    tbl[9]  = '{32'h0, 32'hFE20AC23, 32'hFFFFFFF8, 5'd0, 2'd0, 2'd1, 3'd7, 2'd3, 3'd0, 3'd0, 1'b0, 1'b0}; // sw x2,-8(x1)
    tbl[10] = '{32'h0, 32'h00000073, 32'h00000000, 5'd31, 2'd2, 2'd2, 3'd0, 2'd3, 3'd0, 3'd0, 1'b1, 1'b0}; // ecall
    tbl[11] = '{32'h0, 32'h004012B3, 32'h00000000, 5'd2, 2'd0, 2'd0, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0}; // sll x5,x0,x4

    // Reset: offered input is refused, outputs all zero.
    drive(0, 32'h100);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_data_zero", {31'd0, |{id_pc, id_imm, id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_fn,
        id_rs1_sel, id_rs2_sel, id_mem_fn, id_wb_sel, id_br, id_csr_fn, id_ecall, id_illegal}}, 32'd0);
    if_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_if_ready", {31'd0, if_ready}, 32'd1);

    // Bypass: one-cycle latency from accept to id_valid.
    id_ready = 1'b1;
    drive(0, 32'h100);
    cycle();
    if_valid = 1'b0;
    chk("bypass_latency", {31'd0, id_valid}, 32'd1);
    cycle();
    chk("bypass_drained", sb.size(), 32'd0);

    // Back-to-back stream through the decoder.
    for (int i = 1; i < 12; i++) begin
      drive(i, 32'h1000 + 32'(4 * i));
      cycle();
    end
    if_valid = 1'b0;
    for (int c = 0; c < 10 && sb.size() > 0; c++) cycle();
    chk("stream_drained", sb.size(), 32'd0);

    // Backpressure: output register plus QD queue entries accepted, then stall.
    id_ready = 1'b0;
    k = 0;
    drive(0, 32'h200);
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (acc) begin
        k++;
        drive(k % 12, 32'h200 + 32'(4 * k));
      end
    end
    chk("bp_accepted", sb.size(), QD + 1);
    chk("bp_if_ready_full", {31'd0, if_ready}, 32'd0);
    id_ready = 1'b1;
    chk("bp_pop_no_ready", {31'd0, if_ready}, 32'd0);
    cycle();
    if_valid = 1'b0;
    for (int c = 0; c < 10 && sb.size() > 0; c++) cycle();
    chk("bp_drained", sb.size(), 32'd0);

    // Flush with a full queue and an input offered in the flush cycle.
    id_ready = 1'b0;
    k = 0;
    drive(1, 32'h300);
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (acc) begin
        k++;
        drive(k + 1, 32'h300 + 32'(4 * k));
      end
    end
    flush = 1'b1;
    drive(3, 32'h000DEAD0);
    chk("flush_if_ready", {31'd0, if_ready}, 32'd0);
    cycle();
    flush = 1'b0;
    if_valid = 1'b0;
    chk("flush_id_valid", {31'd0, id_valid}, 32'd0);
    sb.delete();
    cycle();
    chk("flush_queue_empty", {31'd0, id_valid}, 32'd0);
    chk("flush_if_ready_after", {31'd0, if_ready}, 32'd1);
    id_ready = 1'b1;
    drive(5, 32'h400);
    cycle();
    if_valid = 1'b0;
    chk("post_flush_valid", {31'd0, id_valid}, 32'd1);
    cycle();
    chk("post_flush_drained", sb.size(), 32'd0);

    // Asynchronous reset mid-operation.
    id_ready = 1'b0;
    drive(2, 32'h500);
    cycle();
    drive(6, 32'h504);
    cycle();
    if_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("arst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("arst_id_pc", id_pc, 32'd0);
    sb.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cycle();
    chk("arst_queue_empty", {31'd0, id_valid}, 32'd0);
    chk("arst_if_ready_rel", {31'd0, if_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
